snn_inference_sequencer: RTL and testbench
==========================================

// Module: snn_inference_sequencer
// PURPOSE
//  Sequences one classification trial on the 4-in/8-hidden/3-out SNN core: latches a 2x2 pattern and three
//  signed output biases, drives them to the pixel encoder/core for a timed window, counts output spikes,
//  declares a winner, then blanks the pattern for a rest interval so potentials leak back before the next trial.
//  Sits between a host/test driver and aer_pixel_encoder + snn_core_pattern_recognition.
// PARAMETERS
//  WINDOW_CYCLES  2000  presentation window length, cycles (>=1)
//  REST_CYCLES    50    blanking interval after window, pattern forced 4'b0000 (>=0)
//  COUNT_WIDTH    12    per-output spike counter width, saturating
//  EARLY_MARGIN   8     lead (spikes) for early decision; used only with SNN_EARLY_DECISION_EN
// PORTS
//  clk             in   1   single clock; all logic on posedge
//  rst             in   1   synchronous, active-high reset
//  start           in   1   trial request; accepted only when ready=1
//  ready           out  1   1 in IDLE
//  abort           in   1   terminate current trial, go to REST
//  pattern_in      in   4   pattern to classify, sampled on accept
//  bias_in_0..2    in   4   signed biases, sampled on accept
//  pattern_out     out  4   to encoder pixels; 0 outside PRESENT
//  bias_out_0..2   out  4   signed, to core; 0 outside PRESENT
//  spike_out_0..2  in   1   core output spikes
//  result_valid    out  1   1-cycle pulse in DONE
//  winner          out  2   index of max count; held until next accept
//  no_spike        out  1   all counts zero at decision; held with winner
//  count_0..2      out  CW  final counts; held with winner
//  aborted         out  1   held flag: last trial ended by abort
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, pattern_out=0, bias_out_*=0, result_valid=0, winner=0, no_spike=0,
//   count_*=0, aborted=0, timer=0. Reset mid-trial discards everything, same values, next cycle.
//  FSM: IDLE -> PRESENT (start&ready) -> DECIDE (timer==WINDOW_CYCLES-1) -> REST -> DONE -> IDLE.
//   REST_CYCLES=0: REST lasts 0 cycles (DECIDE -> DONE directly).
//  Accept cycle: latch pattern_in/bias_in_*, clear counters and aborted, timer=0. pattern_out/bias_out
//   valid from next cycle; exactly WINDOW_CYCLES cycles in PRESENT.
//  Counting: spike_out_k sampled only in PRESENT; +1 per high cycle, saturates at 2^CW-1, no wrap.
//   Spikes in the last PRESENT cycle are counted; spikes in DECIDE/REST are ignored.
//  DECIDE (1 cycle): winner = argmax(count); ties -> lowest index; all zero -> winner=0, no_spike=1.
//   winner/no_spike/count_* register at end of DECIDE, stable through DONE and IDLE.
//  REST: pattern_out=0, bias_out=0, timer counts REST_CYCLES; result not yet valid.
//  DONE: result_valid=1 for exactly one cycle; start in DONE ignored (ready=0).
//  abort: in PRESENT -> skip DECIDE, enter REST, aborted=1, winner/no_spike/count_* keep previous trial
//   values; DONE still pulses result_valid. Ignored in IDLE/DECIDE/REST/DONE. abort&start same cycle
//   in IDLE: start wins.
//  Total latency accept -> result_valid: WINDOW_CYCLES + REST_CYCLES + 2 cycles.
// CONFIGURATION
//  SNN_EARLY_DECISION_EN defined: in PRESENT, if leading count >= every other count + EARLY_MARGIN,
//   go to DECIDE next cycle (window truncated); early_exit output (1b) held with winner.
//  Undefined: full window always; no early_exit port; EARLY_MARGIN unused.
// STRUCTURE
//  Package snn_ctrl_pkg: state encoding (IDLE, PRESENT, DECIDE, REST, DONE), NUM_OUTPUTS=3,
//   NUM_PIXELS=4, BIAS_WIDTH=4, argmax function with lowest-index tie rule.
//  Sub-module snn_spike_counter (x3): clear, enable, spike -> saturating COUNT_WIDTH count.
//  Top: FSM, timer (width $clog2 of max(WINDOW,REST)+1), latches, argmax register.
// TESTING
//  1 WINDOW=20,REST=5; start pattern 4'b1101 bias(3,0,0), spikes on O0 every 5 cyc only -> counts
//    (4,0,0), winner=0, result_valid exactly 27 cycles after accept; pattern_out=0 during REST.
//  2 Tie: O1,O2 each 3 spikes, O0 0 -> winner=1; no spikes at all -> winner=0, no_spike=1.
//  3 Saturation COUNT_WIDTH=3, O2 high every PRESENT cycle, WINDOW=20 -> count_2=7, winner=2.
//  4 abort on PRESENT cycle 10 after prior result winner=1 -> REST, aborted=1, winner stays 1,
//    result_valid pulses; start during REST/DONE ignored.
//  5 rst asserted mid-PRESENT -> next cycle IDLE, ready=1, all outputs at reset values.
//  6 SNN_EARLY_DECISION_EN, margin 8, O0 spiking each cycle -> DECIDE after 8th spike, early_exit=1.

Source files
------------

// File: rtl/snn_inference_sequencer_pkg.sv
// snn_ctrl_pkg: shared state encoding, network dimensions and the
// argmax helper for the SNN inference sequencer.
// Optional feature macro used by the slice: SNN_EARLY_DECISION_EN.
package snn_ctrl_pkg;

  // Trial sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESENT = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_REST    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int NUM_OUTPUTS = 3;
  localparam int NUM_PIXELS  = 4;
  localparam int BIAS_WIDTH  = 4;

  // Index of the largest of three counts; a later index only wins on a
  // strictly greater count, so ties resolve to the lowest index and an
  // all-zero set yields index 0.
  function automatic logic [1:0] argmax3(input logic [31:0] c0,
                                         input logic [31:0] c1,
                                         input logic [31:0] c2);
    logic [1:0]  idx;
    logic [31:0] best;
    idx  = 2'd0;
    best = c0;
    if (c1 > best) begin
      idx  = 2'd1;
      best = c1;
    end
    if (c2 > best) begin
      idx = 2'd2;
    end
    return idx;
  endfunction

endpackage

// File: rtl/snn_inference_sequencer_if.sv
// snn_seq_if: host / core facing signals of the inference sequencer.
// Handshake: a trial is accepted on a cycle where start=1 and ready=1
// (ready is 1 only in IDLE); start while ready=0 is simply dropped, so
// the host must hold start until it sees ready. result_valid is a
// single-cycle pulse and the result fields stay stable until the next
// accept. early_exit exists only when SNN_EARLY_DECISION_EN is defined.
interface snn_seq_if
  import snn_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 12
) ();

  logic                         start;
  logic                         ready;
  logic                         abort;
  logic [NUM_PIXELS-1:0]        pattern_in;
  logic signed [BIAS_WIDTH-1:0] bias_in_0;
  logic signed [BIAS_WIDTH-1:0] bias_in_1;
  logic signed [BIAS_WIDTH-1:0] bias_in_2;
  logic [NUM_PIXELS-1:0]        pattern_out;
  logic signed [BIAS_WIDTH-1:0] bias_out_0;
  logic signed [BIAS_WIDTH-1:0] bias_out_1;
  logic signed [BIAS_WIDTH-1:0] bias_out_2;
  logic                         spike_out_0;
  logic                         spike_out_1;
  logic                         spike_out_2;
  logic                         result_valid;
  logic [1:0]                   winner;
  logic                         no_spike;
  logic [COUNT_WIDTH-1:0]       count_0;
  logic [COUNT_WIDTH-1:0]       count_1;
  logic [COUNT_WIDTH-1:0]       count_2;
  logic                         aborted;
`ifdef SNN_EARLY_DECISION_EN
  logic                         early_exit;
`endif
  state_e                       dbg_state;

  // Sequencer side
  modport slave (
`ifdef SNN_EARLY_DECISION_EN
    output early_exit,
`endif
    input  start, abort, pattern_in, bias_in_0, bias_in_1, bias_in_2,
    input  spike_out_0, spike_out_1, spike_out_2,
    output ready, pattern_out, bias_out_0, bias_out_1, bias_out_2,
    output result_valid, winner, no_spike, count_0, count_1, count_2,
    output aborted, dbg_state
  );

  // Host / core side
  modport master (
`ifdef SNN_EARLY_DECISION_EN
    input  early_exit,
`endif
    output start, abort, pattern_in, bias_in_0, bias_in_1, bias_in_2,
    output spike_out_0, spike_out_1, spike_out_2,
    input  ready, pattern_out, bias_out_0, bias_out_1, bias_out_2,
    input  result_valid, winner, no_spike, count_0, count_1, count_2,
    input  aborted, dbg_state
  );

endinterface

// File: rtl/snn_inference_sequencer_spike_counter.sv
// snn_spike_counter: per-output saturating spike counter. clear wins
// over counting; the count sticks at all-ones instead of wrapping.
module snn_spike_counter #(
  parameter int COUNT_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   spike_i,
  output logic [COUNT_WIDTH-1:0] count_o
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  // Next count: +1 per enabled spike unless already saturated
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && spike_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/snn_inference_sequencer.sv
// snn_inference_sequencer: runs one classification trial on the SNN core.
// Latches pattern/biases on accept, presents them for WINDOW_CYCLES,
// counts output spikes, registers the argmax winner, blanks the inputs
// for REST_CYCLES and then pulses result_valid.
// Optional feature macro: SNN_EARLY_DECISION_EN (early window exit once
// one output leads every other by EARLY_MARGIN spikes).
module snn_inference_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int WINDOW_CYCLES = 2000,
  parameter int REST_CYCLES   = 50,
  parameter int COUNT_WIDTH   = 12,
  parameter int EARLY_MARGIN  = 8
) (
  input logic      clk,
  input logic      rst,
  snn_seq_if.slave bus
);

  // Timer covers both the window and the rest interval
  localparam int TIMER_MAX = (WINDOW_CYCLES > REST_CYCLES) ? WINDOW_CYCLES : REST_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REST_LAST = TIMER_W'((REST_CYCLES > 0) ? REST_CYCLES - 1 : 0);
  localparam bit HAS_REST = (REST_CYCLES > 0);

  state_e                       state_q;
  logic [TIMER_W-1:0]           timer_q;
  logic                         ready_q;
  logic [NUM_PIXELS-1:0]        pattern_q;
  logic signed [BIAS_WIDTH-1:0] bias_q [NUM_OUTPUTS];
  logic                         result_valid_q;
  logic [1:0]                   winner_q;
  logic                         no_spike_q;
  logic [COUNT_WIDTH-1:0]       count_q [NUM_OUTPUTS];
  logic                         aborted_q;

  logic                         accept;
  logic                         cnt_en;
  logic [NUM_OUTPUTS-1:0]       spike_vec;
  logic [COUNT_WIDTH-1:0]       cnt [NUM_OUTPUTS];
  logic [1:0]                   lead_idx;
  logic                         all_zero;
  logic                         early_hit;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign cnt_en    = (state_q == ST_PRESENT);
  assign spike_vec = {bus.spike_out_2, bus.spike_out_1, bus.spike_out_0};

  // One saturating counter per output neuron, cleared on accept
  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_cnt
    snn_spike_counter #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (accept),
      .enable_i (cnt_en),
      .spike_i  (spike_vec[k]),
      .count_o  (cnt[k])
    );
  end

  // Current leader and the no-spike condition from the live counters
  always_comb begin
    lead_idx = argmax3(32'(cnt[0]), 32'(cnt[1]), 32'(cnt[2]));
    all_zero = (cnt[0] == '0) && (cnt[1] == '0) && (cnt[2] == '0);
  end

`ifdef SNN_EARLY_DECISION_EN
  logic [32:0] lead_w;
  logic [32:0] other_a_w;
  logic [32:0] other_b_w;
  logic        early_pending_q;
  logic        early_exit_q;

  // Leader must be ahead of both other outputs by at least EARLY_MARGIN
  always_comb begin
    lead_w    = '0;
    other_a_w = '0;
    other_b_w = '0;
    case (lead_idx)
      2'd1: begin
        lead_w    = 33'(cnt[1]);
        other_a_w = 33'(cnt[0]);
        other_b_w = 33'(cnt[2]);
      end
      2'd2: begin
        lead_w    = 33'(cnt[2]);
        other_a_w = 33'(cnt[0]);
        other_b_w = 33'(cnt[1]);
      end
      default: begin
        lead_w    = 33'(cnt[0]);
        other_a_w = 33'(cnt[1]);
        other_b_w = 33'(cnt[2]);
      end
    endcase
    early_hit = (lead_w >= other_a_w + 33'(EARLY_MARGIN)) &&
                (lead_w >= other_b_w + 33'(EARLY_MARGIN));
  end

  // Early-exit flag: armed when the window is cut short, published with the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      early_pending_q <= 1'b0;
      early_exit_q    <= 1'b0;
    end else begin
      if (accept) begin
        early_pending_q <= 1'b0;
      end else if ((state_q == ST_PRESENT) && !bus.abort && early_hit &&
                   (timer_q != WIN_LAST)) begin
        early_pending_q <= 1'b1;
      end
      if (state_q == ST_DECIDE) begin
        early_exit_q <= early_pending_q;
      end
    end
  end

  assign bus.early_exit = early_exit_q;
`else
  localparam int unused_early_margin = EARLY_MARGIN;
  assign early_hit = 1'b0;
`endif

  // Trial FSM: state, timer, input latches and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      ready_q        <= 1'b1;
      pattern_q      <= '0;
      bias_q[0]      <= '0;
      bias_q[1]      <= '0;
      bias_q[2]      <= '0;
      result_valid_q <= 1'b0;
      winner_q       <= 2'd0;
      no_spike_q     <= 1'b0;
      count_q[0]     <= '0;
      count_q[1]     <= '0;
      count_q[2]     <= '0;
      aborted_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_PRESENT;
            ready_q   <= 1'b0;
            timer_q   <= '0;
            aborted_q <= 1'b0;
            pattern_q <= bus.pattern_in;
            bias_q[0] <= bus.bias_in_0;
            bias_q[1] <= bus.bias_in_1;
            bias_q[2] <= bus.bias_in_2;
          end
        end
        ST_PRESENT: begin
          if (bus.abort) begin
            // Abandon the window; previous result stays on the outputs
            state_q        <= HAS_REST ? ST_REST : ST_DONE;
            result_valid_q <= !HAS_REST;
            aborted_q      <= 1'b1;
            timer_q        <= '0;
            pattern_q      <= '0;
            bias_q[0]      <= '0;
            bias_q[1]      <= '0;
            bias_q[2]      <= '0;
          end else if ((timer_q == WIN_LAST) || early_hit) begin
            state_q   <= ST_DECIDE;
            timer_q   <= '0;
            pattern_q <= '0;
            bias_q[0] <= '0;
            bias_q[1] <= '0;
            bias_q[2] <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          winner_q       <= lead_idx;
          no_spike_q     <= all_zero;
          count_q[0]     <= cnt[0];
          count_q[1]     <= cnt[1];
          count_q[2]     <= cnt[2];
          timer_q        <= '0;
          state_q        <= HAS_REST ? ST_REST : ST_DONE;
          result_valid_q <= !HAS_REST;
        end
        ST_REST: begin
          if (timer_q == REST_LAST) begin
            state_q        <= ST_DONE;
            result_valid_q <= 1'b1;
            timer_q        <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign bus.ready        = ready_q;
  assign bus.pattern_out  = pattern_q;
  assign bus.bias_out_0   = bias_q[0];
  assign bus.bias_out_1   = bias_q[1];
  assign bus.bias_out_2   = bias_q[2];
  assign bus.result_valid = result_valid_q;
  assign bus.winner       = winner_q;
  assign bus.no_spike     = no_spike_q;
  assign bus.count_0      = count_q[0];
  assign bus.count_1      = count_q[1];
  assign bus.count_2      = count_q[2];
  assign bus.aborted      = aborted_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Testbench for snn_inference_sequencer (default build, early decision off).
// WINDOW=20, REST=5, COUNT_WIDTH=3 so saturation is reachable in one window.
module tb_snn_inference_sequencer;
  import snn_ctrl_pkg::*;

  localparam int W    = 20;
  localparam int R    = 5;
  localparam int CW   = 3;
  localparam int MAXC = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_seq_if #(.COUNT_WIDTH(CW)) bus ();

  snn_inference_sequencer #(
    .WINDOW_CYCLES (W),
    .REST_CYCLES   (R),
    .COUNT_WIDTH   (CW),
    .EARLY_MARGIN  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];       // {aborted, no_spike, winner, c2, c1, c0}
  logic        sp [0:2][1:W];  // spike plan per output per PRESENT cycle
  logic [1:0]    prev_w;
  logic          prev_ns;
  logic [CW-1:0] prev_c [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_spikes(input int mode);
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= W; c++) begin
        case (mode)
          1: sp[k][c] = (k == 0) && (c % 5 == 0);
          2: sp[k][c] = ((k == 1) && (c == 2 || c == 4 || c == 6)) ||
                        ((k == 2) && (c == 3 || c == 5 || c == 7));
          3: sp[k][c] = (k == 2);
          4: sp[k][c] = ($urandom_range(0, 99) < 15 + 10 * k);
          default: sp[k][c] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    chk({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
    chk({tag, "_drive"}, 32'({bus.pattern_out, bus.bias_out_0, bus.bias_out_1, bus.bias_out_2}), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_winner"}, 32'(bus.winner), 32'd0);
    chk({tag, "_nospike"}, 32'(bus.no_spike), 32'd0);
    chk({tag, "_counts"}, 32'({bus.count_2, bus.count_1, bus.count_0}), 32'd0);
    chk({tag, "_aborted"}, 32'(bus.aborted), 32'd0);
  endtask

  // One trial; abort_at>0 asserts abort in that PRESENT cycle (1-based)
  task automatic run_trial(input logic [3:0] pat, input logic [3:0] b0,
                           input logic [3:0] b1, input logic [3:0] b2,
                           input int abort_at, input bit abort_with_start);
    int            sums [3];
    logic [CW-1:0] ec [3];
    logic [1:0]    ew;
    logic          ens;
    logic [12:0]   expv;
    logic [12:0]   gotv;
    logic [15:0]   drv_exp;
    int            end_p;
    int            done_c;
    bit            present;
    end_p  = (abort_at > 0) ? abort_at : W;
    done_c = (abort_at > 0) ? abort_at + R + 1 : W + R + 2;
    if (abort_at > 0) begin
      expv = {1'b1, prev_ns, prev_w, prev_c[2], prev_c[1], prev_c[0]};
    end else begin
      for (int k = 0; k < 3; k++) begin
        sums[k] = 0;
        for (int c = 1; c <= W; c++) sums[k] += int'(sp[k][c]);
        ec[k] = CW'((sums[k] > MAXC) ? MAXC : sums[k]);
      end
      ew = 2'd0;
      for (int k = 1; k < 3; k++) if (ec[k] > ec[ew]) ew = 2'(k);
      ens = (sums[0] + sums[1] + sums[2]) == 0;
      expv = {1'b0, ens, ew, ec[2], ec[1], ec[0]};
      prev_w = ew; prev_ns = ens;
      for (int k = 0; k < 3; k++) prev_c[k] = ec[k];
    end
    exp_q.push_back(expv);

    bus.start = 1'b1; bus.abort = abort_with_start;
    bus.pattern_in = pat; bus.bias_in_0 = b0; bus.bias_in_1 = b1; bus.bias_in_2 = b2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pattern_in = 4'($urandom_range(0, 15));
    for (int c = 1; c <= W + R + 3; c++) begin
      present = (c <= end_p);
      drv_exp = present ? {pat, b0, b1, b2} : 16'h0;
      chk("drive", 32'({bus.pattern_out, bus.bias_out_0, bus.bias_out_1, bus.bias_out_2}), 32'(drv_exp));
      chk("result_valid", 32'(bus.result_valid), 32'(c == done_c));
      chk("ready", 32'(bus.ready), 32'(c > done_c));
      if (c == done_c) begin
        expv = exp_q.pop_front();
        chk("aborted", 32'(bus.aborted), 32'(expv[12]));
        chk("no_spike", 32'(bus.no_spike), 32'(expv[11]));
        chk("winner", 32'(bus.winner), 32'(expv[10:9]));
        chk("counts", 32'({bus.count_2, bus.count_1, bus.count_0}), 32'(expv[8:0]));
      end
      if (c == done_c + 1) begin
        gotv = {bus.aborted, bus.no_spike, bus.winner, bus.count_2, bus.count_1, bus.count_0};
        chk("held_result", 32'(gotv), 32'(expv));
        break;
      end
      if (present) begin
        bus.spike_out_0 = sp[0][c]; bus.spike_out_1 = sp[1][c]; bus.spike_out_2 = sp[2][c];
        bus.abort = (c == abort_at);
      end else begin
        // DECIDE/REST/DONE: spikes, abort and start must all be ignored
        bus.spike_out_0 = 1'($urandom_range(0, 1));
        bus.spike_out_1 = 1'($urandom_range(0, 1));
        bus.spike_out_2 = 1'($urandom_range(0, 1));
        bus.abort = 1'($urandom_range(0, 1));
        bus.start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.spike_out_0 = 1'b0; bus.spike_out_1 = 1'b0; bus.spike_out_2 = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern_in = 4'h0;
    bus.bias_in_0 = 4'h0; bus.bias_in_1 = 4'h0; bus.bias_in_2 = 4'h0;
    bus.spike_out_0 = 1'b0; bus.spike_out_1 = 1'b0; bus.spike_out_2 = 1'b0;
    prev_w = 2'd0; prev_ns = 1'b0;
    for (int k = 0; k < 3; k++) prev_c[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // O0 every 5th cycle -> (4,0,0), winner 0, latency W+R+2
    fill_spikes(1);
    run_trial(4'b1101, 4'd3, 4'd0, 4'd0, 0, 1'b0);
    // Tie between O1 and O2 -> lowest index 1
    fill_spikes(2);
    run_trial(4'b0110, 4'hF, 4'd2, 4'h9, 0, 1'b0);
    // No spikes -> winner 0, no_spike 1
    fill_spikes(0);
    run_trial(4'b1001, 4'd1, 4'd1, 4'd1, 0, 1'b0);
    // Prior winner 1, then abort in PRESENT cycle 10 keeps it
    fill_spikes(2);
    run_trial(4'b0011, 4'd0, 4'd5, 4'hC, 0, 1'b0);
    fill_spikes(4);
    run_trial(4'b1111, 4'd7, 4'h8, 4'd4, 10, 1'b0);
    // O2 every PRESENT cycle saturates at 7
    fill_spikes(3);
    run_trial(4'b1010, 4'd2, 4'hE, 4'd6, 0, 1'b0);
    // abort together with start in IDLE: start wins, normal trial
    fill_spikes(1);
    run_trial(4'b0101, 4'h4, 4'h3, 4'h2, 0, 1'b1);

    // Random trials, some aborted
    for (int t = 0; t < 8; t++) begin
      fill_spikes(4);
      run_trial(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0,
                1'($urandom_range(0, 1)));
    end

    // Reset in the middle of PRESENT discards the trial
    fill_spikes(4);
    bus.start = 1'b1; bus.pattern_in = 4'b1110;
    bus.bias_in_0 = 4'd5; bus.bias_in_1 = 4'd6; bus.bias_in_2 = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      bus.spike_out_0 = sp[0][c]; bus.spike_out_1 = sp[1][c]; bus.spike_out_2 = sp[2][c];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.spike_out_0 = 1'b0; bus.spike_out_1 = 1'b0; bus.spike_out_2 = 1'b0;
    check_reset_state("midrst");
    prev_w = 2'd0; prev_ns = 1'b0;
    for (int k = 0; k < 3; k++) prev_c[k] = '0;

    // Abort right after reset reports the reset-value result
    fill_spikes(4);
    run_trial(4'b0111, 4'd1, 4'd2, 4'd3, 3, 1'b0);
    fill_spikes(4);
    run_trial(4'b1000, 4'd3, 4'd2, 4'd1, 0, 1'b0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
